// File: rtl/rc_car_pkg.sv
// Shared types and constants for the RC car drive controller.
package rc_car_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        FWD   = 3'd1,
        REV   = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam logic [1:0] M_OFF = 2'b00;
    localparam logic [1:0] M_POS = 2'b01;
    localparam logic [1:0] M_NEG = 2'b10;

    localparam int DUTY_W = 8;

    // Returns {right_channel, left_channel} for a drive target.
    function automatic logic [3:0] motor_enc(cmd_e c);
        case (c)
            FWD:     return {M_NEG, M_POS};
            REV:     return {M_POS, M_NEG};
            LEFT:    return {M_OFF, M_POS};
            RIGHT:   return {M_NEG, M_OFF};
            default: return {M_OFF, M_OFF};
        endcase
    endfunction

endpackage

// File: rtl/pwm_ramp.sv
// Free-running PWM with a saturating soft-start duty ramp, active while run_en is high.
module pwm_ramp
    import rc_car_pkg::*;
#(
    parameter int RAMP_CYC = 50000,
    parameter int RAMP_INC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run_en,
    output logic pwm_on
);

    localparam int RW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [RW-1:0]     ramp_cnt_q, ramp_cnt_d;
    logic [DUTY_W:0]   duty_sum;

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        duty_sum   = {1'b0, duty_q} + (DUTY_W+1)'(RAMP_INC);
        duty_d     = duty_q;
        ramp_cnt_d = ramp_cnt_q;
        if (!run_en) begin
            duty_d     = '0;
            ramp_cnt_d = '0;
        end else if (ramp_cnt_q == RW'(RAMP_CYC - 1)) begin
            ramp_cnt_d = '0;
            // Saturate rather than wrap so the motor never drops back to zero drive.
            duty_d     = (duty_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : duty_sum[DUTY_W-1:0];
        end else begin
            ramp_cnt_d = ramp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            duty_q     <= '0;
            ramp_cnt_q <= '0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            duty_q     <= duty_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    assign pwm_on = (duty_q == DUTY_MAX) || (pwm_cnt_q < duty_q);

endmodule

// File: rtl/drive_sequencer.sv
// Drive controller: button arbitration, H-bridge dead-time sequencing, soft-start and indicators.
// state | meaning
// IDLE  | no request, motors off, brake lamps on
// DEAD  | coasting for the dead-time before driving the new target
// RUN   | driving target with PWM soft-start, brake lamps off
module drive_sequencer
    import rc_car_pkg::*;
#(
    parameter int DEAD_CYC  = 500000,
    parameter int BLINK_CYC = 25000000,
    parameter int RAMP_CYC  = 50000,
    parameter int RAMP_INC  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] left_motor,
    output logic [1:0] right_motor,
    output logic       left_ind,
    output logic       right_ind,
    output logic       brake_light,
    output logic [1:0] state_o
);

    localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    logic [3:0]    btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    cmd_e          cmd;
    state_e        state_q, state_d;
    cmd_e          target_q, target_d;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_tog_q, blink_tog_d;
    logic          new_tgt;
    logic          run_en;
    logic          pwm_on;
    logic [3:0]    motor_pair;

    logic [1:0] left_motor_q, left_motor_d, right_motor_q, right_motor_d;
    logic       left_ind_q, left_ind_d, right_ind_q, right_ind_d;
    logic       brake_light_q, brake_light_d;
    logic [1:0] state_o_q, state_o_d;

    // Buttons are asynchronous; two flops before any decode.
    always_comb begin
        btn_s1_d = {btn_right, btn_left, btn_down, btn_up};
        btn_s2_d = btn_s1_q;
        cmd      = NONE;
        if (btn_s2_q[0])      cmd = FWD;
        else if (btn_s2_q[1]) cmd = REV;
        else if (btn_s2_q[2]) cmd = LEFT;
        else if (btn_s2_q[3]) cmd = RIGHT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q      <= '0;
            btn_s2_q      <= '0;
            state_q       <= IDLE;
            target_q      <= NONE;
            dead_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_tog_q   <= 1'b0;
            left_motor_q  <= M_OFF;
            right_motor_q <= M_OFF;
            left_ind_q    <= 1'b0;
            right_ind_q   <= 1'b0;
            brake_light_q <= 1'b1;
            state_o_q     <= IDLE;
        end else begin
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            state_q       <= state_d;
            target_q      <= target_d;
            dead_cnt_q    <= dead_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_tog_q   <= blink_tog_d;
            left_motor_q  <= left_motor_d;
            right_motor_q <= right_motor_d;
            left_ind_q    <= left_ind_d;
            right_ind_q   <= right_ind_d;
            brake_light_q <= brake_light_d;
            state_o_q     <= state_o_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        dead_cnt_d = dead_cnt_q;
        new_tgt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd != NONE) begin
                    state_d    = DEAD;
                    target_d   = cmd;
                    dead_cnt_d = '0;
                    new_tgt    = 1'b1;
                end
            end
            DEAD: begin
                if (cmd == NONE) begin
                    state_d    = IDLE;
                    target_d   = NONE;
                    dead_cnt_d = '0;
                end else if (cmd != target_q) begin
                    target_d   = cmd;
                    dead_cnt_d = '0;
                    new_tgt    = 1'b1;
                end else if (dead_cnt_q == DW'(DEAD_CYC - 1)) begin
                    state_d    = RUN;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cmd == NONE) begin
                    state_d  = IDLE;
                    target_d = NONE;
                end else if (cmd != target_q) begin
                    state_d    = DEAD;
                    target_d   = cmd;
                    dead_cnt_d = '0;
                    new_tgt    = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                target_d   = NONE;
                dead_cnt_d = '0;
            end
        endcase

        blink_cnt_d = blink_cnt_q;
        blink_tog_d = blink_tog_q;
        if (state_d == IDLE || new_tgt) begin
            blink_cnt_d = '0;
            blink_tog_d = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
            blink_cnt_d = '0;
            blink_tog_d = ~blink_tog_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    assign run_en = (state_q == RUN);

    pwm_ramp #(
        .RAMP_CYC (RAMP_CYC),
        .RAMP_INC (RAMP_INC)
    ) u_pwm_ramp (
        .clk    (clk),
        .rst    (rst),
        .run_en (run_en),
        .pwm_on (pwm_on)
    );

    always_comb begin
        motor_pair    = motor_enc(target_q);
        left_motor_d  = M_OFF;
        right_motor_d = M_OFF;
        if (run_en && pwm_on) begin
            left_motor_d  = motor_pair[1:0];
            right_motor_d = motor_pair[3:2];
        end
        left_ind_d    = (state_q != IDLE) && (target_q == LEFT) && blink_tog_q;
        right_ind_d   = (state_q != IDLE) && (target_q == RIGHT) && blink_tog_q;
        brake_light_d = !run_en;
        state_o_d     = state_q;
    end

    assign left_motor  = left_motor_q;
    assign right_motor = right_motor_q;
    assign left_ind    = left_ind_q;
    assign right_ind   = right_ind_q;
    assign brake_light = brake_light_q;
    assign state_o     = state_o_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with short timing parameters.
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0] left_motor, right_motor, state_o;
    logic       left_ind, right_ind, brake_light;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    drive_sequencer #(
        .DEAD_CYC  (4),
        .BLINK_CYC (8),
        .RAMP_CYC  (2),
        .RAMP_INC  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .left_motor  (left_motor),
        .right_motor (right_motor),
        .left_ind    (left_ind),
        .right_ind   (right_ind),
        .brake_light (brake_light),
        .state_o     (state_o)
    );

    typedef struct {
        logic [3:0]  btn;
        int          hold;
        logic [8:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] pk(logic [1:0] l, logic [1:0] r, logic li, logic ri,
                                      logic b, logic [1:0] st);
        return {l, r, li, ri, b, st};
    endfunction

    function automatic logic [8:0] obs();
        return {left_motor, right_motor, left_ind, right_ind, brake_light, state_o};
    endfunction

    function automatic vec_t mkv(logic [3:0] b, int h, logic [8:0] e, string n);
        vec_t v;
        v.btn  = b;
        v.hold = h;
        v.exp  = e;
        v.name = n;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // btn = {right, left, down, up}
    task automatic set_btn(logic [3:0] b);
        {btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Channel safety monitor: never 11, never a reversal with fewer than 4 off cycles.
    logic [1:0] ch[2];
    logic [1:0] last_nz[2] = '{2'b00, 2'b00};
    int         zrun[2] = '{0, 0};

    always @(negedge clk) begin
        if (!rst) begin
            ch[0] = left_motor;
            ch[1] = right_motor;
            for (int c = 0; c < 2; c++) begin
                if (ch[c] == 2'b11) viol++;
                else if (ch[c] == 2'b00) zrun[c]++;
                else begin
                    if (last_nz[c] != 2'b00 && last_nz[c] != ch[c] && zrun[c] < 4) viol++;
                    last_nz[c] = ch[c];
                    zrun[c]    = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    localparam logic [8:0] IDLE_EXP = 9'b00_00_0_0_1_00;

    logic [1:0] es, el, er;
    logic       eb, eli;
    int         zeros;
    logic       found;

    initial begin
        vecs.push_back(mkv(4'b0001, 30, pk(2'b01, 2'b10, 0, 0, 0, 2'd2), "fwd_run"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_1"));
        vecs.push_back(mkv(4'b0010,  5, pk(2'b00, 2'b00, 0, 0, 1, 2'd1), "rev_dead"));
        vecs.push_back(mkv(4'b0010, 25, pk(2'b10, 2'b01, 0, 0, 0, 2'd2), "rev_run"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_2"));
        vecs.push_back(mkv(4'b0100, 30, pk(2'b01, 2'b00, 1, 0, 0, 2'd2), "left_run"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_3"));
        vecs.push_back(mkv(4'b1000, 30, pk(2'b00, 2'b10, 0, 1, 0, 2'd2), "right_run"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_4"));
        vecs.push_back(mkv(4'b1111, 30, pk(2'b01, 2'b10, 0, 0, 0, 2'd2), "all_four_fwd"));
        vecs.push_back(mkv(4'b0110, 30, pk(2'b10, 2'b01, 0, 0, 0, 2'd2), "down_left_rev"));
        vecs.push_back(mkv(4'b1100, 30, pk(2'b01, 2'b00, 1, 0, 0, 2'd2), "left_right_left"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_5"));
        vecs.push_back(mkv(4'b1000,  3, IDLE_EXP,                         "right_sync_lat"));
        vecs.push_back(mkv(4'b1000, 27, pk(2'b00, 2'b10, 0, 1, 0, 2'd2), "right_run_2"));
        vecs.push_back(mkv(4'b0000,  6, IDLE_EXP,                         "idle_6"));

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", obs(), IDLE_EXP);
        rst = 1'b0;

        // Idle long enough that the PWM counter sits at 150 when up is pressed.
        repeat (150) tick();
        chk("idle_before_press", obs(), IDLE_EXP);

        set_btn(4'b0001);
        for (int n = 1; n <= 20; n++) begin
            tick();
            es = (n <= 3) ? 2'd0 : (n <= 7) ? 2'd1 : 2'd2;
            eb = (n <= 7);
            el = (n >= 14) ? 2'b01 : 2'b00;
            er = (n >= 14) ? 2'b10 : 2'b00;
            chk($sformatf("fwd_ramp_c%0d", n), obs(), pk(el, er, 0, 0, eb, es));
        end

        // Reset mid-RUN with up held.
        rst = 1'b1;
        #1;
        chk("reset_mid_run", obs(), IDLE_EXP);
        tick();
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            es = (n <= 3) ? 2'd0 : (n <= 7) ? 2'd1 : 2'd2;
            eb = (n <= 7);
            chk($sformatf("post_reset_c%0d", n), obs(), pk(2'b00, 2'b00, 0, 0, eb, es));
        end
        set_btn(4'b0000);
        repeat (6) tick();

        foreach (vecs[i]) begin
            set_btn(vecs[i].btn);
            repeat (vecs[i].hold) tick();
            chk(vecs[i].name, obs(), vecs[i].exp);
        end

        // Up held, down added: priority keeps FWD; dropping up reverses after a coast gap.
        set_btn(4'b0001);
        repeat (30) tick();
        set_btn(4'b0011);
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("up_down_prio_c%0d", n), obs(), pk(2'b01, 2'b10, 0, 0, 0, 2'd2));
        end
        set_btn(4'b0010);
        zeros = 0;
        found = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (left_motor == 2'b10) begin
                found = 1'b1;
                break;
            end
            if (left_motor == 2'b00) zeros++;
        end
        chk("reverse_reached", found, 1);
        chk("reverse_coast_ge4", (zeros >= 4), 1);
        chk("reverse_right_ch", right_motor, 2'b01);
        set_btn(4'b0000);
        repeat (6) tick();

        // Left indicator blink phase.
        set_btn(4'b0100);
        for (int n = 1; n <= 40; n++) begin
            tick();
            eli = (n >= 12) && (((n - 12) / 8) % 2 == 0);
            chk($sformatf("left_blink_c%0d", n), {right_motor, left_ind, right_ind},
                {2'b00, eli, 1'b0});
        end
        set_btn(4'b0000);
        repeat (4) tick();
        chk("left_release", {left_ind, brake_light}, 2'b01);
        repeat (4) tick();

        // Down/right alternating every 2 cycles never completes a dead interval.
        for (int k = 0; k < 20; k++) begin
            set_btn((k % 2 == 0) ? 4'b0010 : 4'b1000);
            for (int j = 0; j < 2; j++) begin
                tick();
                chk($sformatf("toggle_k%0d_j%0d", k, j),
                    {left_motor, right_motor, (state_o == 2'd2)}, 5'b0);
            end
        end
        chk("toggle_in_dead", state_o, 2'd1);
        set_btn(4'b0000);
        repeat (6) tick();
        chk("final_idle", obs(), IDLE_EXP);

        chk("channel_safety_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Central drive controller for the DE-10 Lite RC car. It sits between the four drive buttons and the two H-bridge motor channels, indicators and brake lights. It arbitrates button requests and enforces a coast dead-time before every direction change to protect the H-bridge. It also applies a PWM soft-start ramp to the active motor pins and generates indicator blink.

Parameters:
DEAD_CYC, 500000, coast cycles between any two different drive directions (10 ms at 50 MHz)
BLINK_CYC, 25000000, indicator half-period in cycles
RAMP_CYC, 50000, cycles between duty increments in RUN
RAMP_INC, 8, duty increment per step; duty saturates at 255

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset; asynchronous, active-high
btn_up  in  1  forward request, asynchronous
btn_down  in  1  reverse request, asynchronous
btn_left  in  1  left-turn request, asynchronous
btn_right  in  1  right-turn request, asynchronous
left_motor  out  2  left H-bridge pins; [0]=drive+, [1]=drive-
right_motor  out  2  right H-bridge pins; [0]=drive+, [1]=drive-
left_ind  out  1  left indicator lamp
right_ind  out  1  right indicator lamp
brake_light  out  1  drives both brake lamps
state_o  out  2  FSM state, for debug LEDs

Behaviour:
- Reset (async, active-high):
  - state=IDLE, target=NONE, all counters 0, duty 0.
  - left_motor=right_motor=2'b00, left_ind=right_ind=0, brake_light=1.
- Input path:
  - Each button passes through a 2-FF synchronizer.
  - Decoded command, priority UP > DOWN > LEFT > RIGHT > NONE. Simultaneous presses resolve by this priority.
- Motor encoding per target:
  - FWD: L=01, R=10
  - REV: L=10, R=01
  - LEFT: L=01, R=00
  - RIGHT: L=00, R=10
  - NONE: both 00
  - Invariant: a channel never shows 2'b11.
  - A channel never switches from 01 to 10, or 10 to 01, without at least DEAD_CYC cycles of 00 in between.
- FSM states: IDLE=0, DEAD=1, RUN=2.
  - IDLE: cmd!=NONE -> DEAD; target<=cmd; dead_cnt<=0.
  - DEAD:
    - cmd==NONE -> IDLE.
    - cmd!=target -> stay in DEAD, target<=cmd, dead_cnt<=0 (restart).
    - Otherwise dead_cnt increments; at dead_cnt==DEAD_CYC-1 -> RUN, duty<=0.
  - RUN:
    - cmd==target -> stay.
    - cmd==NONE -> IDLE.
    - Any other cmd -> DEAD, target<=cmd, dead_cnt<=0.
- PWM:
  - 8-bit free-running pwm_cnt.
  - pwm_on = (duty==255) | (pwm_cnt < duty).
  - In RUN, ramp_cnt counts to RAMP_CYC-1, then duty <= min(duty+RAMP_INC, 255).
  - Outside RUN, duty=0 and ramp_cnt=0.
  - Motor pins = encoding(target) AND pwm_on in RUN; 00 in IDLE and DEAD.
- brake_light: 1 in IDLE and DEAD, 0 in RUN.
- Indicators:
  - Active only in DEAD or RUN with target=LEFT (left_ind) or RIGHT (right_ind); the other indicator is 0.
  - On target change or entry from IDLE: indicator=0, blink_cnt=0.
  - Toggles when blink_cnt==BLINK_CYC-1, then blink_cnt<=0.
  - Forced 0 in IDLE.
- Latency:
  - Button edge -> decoded cmd: 2 cycles.
  - FSM updates on the next edge.
  - All outputs are registered: 1 further cycle. Total 4 cycles from button change to output change.
- Reset mid-operation: all outputs return to reset values immediately. After release, a fresh DEAD interval is required before any drive.

Decomposition:
- Package rc_car_pkg holds:
  - cmd_e enum: NONE, FWD, REV, LEFT, RIGHT
  - state_e enum: IDLE, DEAD, RUN
  - 2-bit motor encoding constants: M_OFF=00, M_POS=01, M_NEG=10
  - duty width constant: 8
- Sub-module pwm_ramp owns pwm_cnt, ramp_cnt and duty.
  - Ports: clk, rst, run_en, pwm_on.
  - Parameters: RAMP_CYC, RAMP_INC.

Test Plan (DEAD_CYC=4, BLINK_CYC=8, RAMP_CYC=2, RAMP_INC=64):
1. Reset asserted mid-RUN with btn_up held -> motors 00 and brake_light=1 in the same cycle. After release: IDLE, then DEAD for 4 cycles, then RUN.
2. btn_up held from IDLE -> motors 00 for 4 dead cycles, then left_motor=01 and right_motor=10 gated by PWM. Duty steps 0,64,128,192,255 every 2 cycles; pwm_on is constant 1 at 255.
3. btn_up held, then btn_down added -> FWD continues (priority). Release btn_up -> both channels 00 for ≥4 cycles, then L=10 and R=01. A 2'b11 is never seen.
4. btn_left held 40 cycles -> left_ind starts 0 and toggles every 8 cycles; right_ind stays 0; right_motor=00. Release -> left_ind=0 and brake_light=1 within 4 cycles.
5. btn_down and btn_right toggled alternately every 2 cycles -> FSM stays in DEAD (counter restarts on each change), motors stay 00 throughout.
6. All four buttons pressed in the same cycle -> FWD selected. Assertions hold for the whole run: no channel ever 2'b11, and no direct 01<->10 channel transition.
